// File: rtl/conv_win_sched_if.sv
// Bundles the scheduler's bus-side signals: the column-store fetch
// handshake, the PE trigger/result path and the downstream result stream.
//
// Handshake rule for both valid/ready pairs (col_req/col_gnt and
// out_valid/out_ready): a transfer happens on a rising clock edge where both
// are high. Once the request/valid side is raised, it and its payload stay
// stable until that edge.
//
// Signals (master = scheduler side):
//   col_req, col_row, col_col   -> column fetch request and address
//   col_gnt                     <- column fetch accepted this cycle
//   pe_trigger                  -> one-cycle window MAC start
//   res_valid, res_data         <- PE result strobe and signed value
//   out_valid, out_data,
//   out_row, out_col            -> captured result and its output position
//   out_ready                   <- downstream accepts
interface conv_win_sched_if #(
  parameter int IN_H  = 16,
  parameter int IN_W  = 15,
  parameter int RES_W = 24
);
  localparam int ROW_W = $clog2(IN_H);
  localparam int COL_W = $clog2(IN_W);

  logic                    col_req;
  logic [ROW_W-1:0]        col_row;
  logic [COL_W-1:0]        col_col;
  logic                    col_gnt;
  logic                    pe_trigger;
  logic                    res_valid;
  logic signed [RES_W-1:0] res_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [RES_W-1:0] out_data;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;

  modport master (
    output col_req, col_row, col_col, pe_trigger,
    output out_valid, out_data, out_row, out_col,
    input  col_gnt, res_valid, res_data, out_ready
  );

  modport slave (
    input  col_req, col_row, col_col, pe_trigger,
    input  out_valid, out_data, out_row, out_col,
    output col_gnt, res_valid, res_data, out_ready
  );
endinterface

// File: rtl/conv_win_sched.sv
// Autonomous window scheduler. Walks output positions in raster order; for
// each one it fetches the image columns needed (a full K_W columns at the
// start of a row, one new column when sliding right), fires the PE, waits
// for its result and offers it downstream.
//
// Ports:
//   clk, rst_ni      clock, asynchronous active-low reset
//   start            begin one image pass (ignored while busy)
//   abort            synchronous abort back to IDLE, beats any handshake
//   busy             state != IDLE
//   done             one-cycle end-of-pass pulse
//   win_clear        one-cycle clear of the image circular register
//   dbg_state        current FSM state
//   bus              fetch / PE / result-stream interface (master side)
module conv_win_sched #(
  parameter int K_H   = 3,
  parameter int K_W   = 3,
  parameter int IN_H  = 16,
  parameter int IN_W  = 15,
  parameter int RES_W = 24,
  parameter int RELU  = 0
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             win_clear,
  output logic [2:0]       dbg_state,
  conv_win_sched_if.master bus
);
  localparam int OUT_H = IN_H - K_H + 1;
  localparam int OUT_W = IN_W - K_W + 1;
  localparam int ROW_W = $clog2(IN_H);
  localparam int COL_W = $clog2(IN_W);
  localparam int CNT_W = $clog2(K_W + 1);

  localparam logic [ROW_W-1:0] LAST_OROW = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0] LAST_OCOL = COL_W'(OUT_W - 1);
  localparam logic [COL_W-1:0] LAST_NCOL = COL_W'(IN_W - 1);
  localparam bit               RELU_EN   = (RELU != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_TRIG = 3'd3,
    S_WAIT = 3'd4,
    S_EMIT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                  r_state, w_next;
  logic [ROW_W-1:0]        r_orow;
  logic [COL_W-1:0]        r_ocol;
  logic [COL_W-1:0]        r_ncol;
  logic [CNT_W-1:0]        r_ldcnt;
  logic [CNT_W-1:0]        r_need;
  logic signed [RES_W-1:0] r_out_data;
  logic [ROW_W-1:0]        r_out_row;
  logic [COL_W-1:0]        r_out_col;

  // Handshakes that actually take effect; abort discards all of them.
  logic w_start_acc, w_col_hs, w_res_hs, w_out_hs;
  logic w_ld_last, w_last_col, w_last_row;
  logic signed [RES_W-1:0] w_res_val;

  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_col_hs    = (r_state == S_LOAD) && bus.col_gnt && !abort;
  assign w_res_hs    = (r_state == S_WAIT) && bus.res_valid && !abort;
  assign w_out_hs    = (r_state == S_EMIT) && bus.out_ready && !abort;
  assign w_ld_last   = (r_ldcnt == r_need - CNT_W'(1));
  assign w_last_col  = (r_ocol == LAST_OCOL);
  assign w_last_row  = (r_orow == LAST_OROW);
  assign w_res_val   = (RELU_EN && bus.res_data[RES_W-1]) ? '0 : bus.res_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CLR;
      S_CLR:  w_next = S_LOAD;
      S_LOAD: if (bus.col_gnt && w_ld_last) w_next = S_TRIG;
      S_TRIG: w_next = S_WAIT;
      S_WAIT: if (bus.res_valid) w_next = S_EMIT;
      S_EMIT: begin
        if (bus.out_ready) begin
          if (!w_last_col)      w_next = S_LOAD;
          else if (!w_last_row) w_next = S_CLR;
          else                  w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Also blocks start in IDLE when both arrive together.
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_orow     <= '0;
      r_ocol     <= '0;
      r_ncol     <= '0;
      r_ldcnt    <= '0;
      r_need     <= '0;
      r_out_data <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_orow <= '0;
        r_ocol <= '0;
      end
      if (r_state == S_CLR && !abort) begin
        r_ncol  <= '0;
        r_need  <= CNT_W'(K_W);
        r_ldcnt <= '0;
      end
      if (w_col_hs) begin
        // The last fetch of a row is column IN_W-1; hold there rather than
        // step past the image edge.
        if (r_ncol != LAST_NCOL) r_ncol <= r_ncol + COL_W'(1);
        r_ldcnt <= r_ldcnt + CNT_W'(1);
      end
      if (w_res_hs) begin
        r_out_data <= w_res_val;
        r_out_row  <= r_orow;
        r_out_col  <= r_ocol;
      end
      if (w_out_hs) begin
        if (!w_last_col) begin
          // Slide right: the window already holds K_W-1 of the columns.
          r_ocol  <= r_ocol + COL_W'(1);
          r_need  <= CNT_W'(1);
          r_ldcnt <= '0;
        end else if (!w_last_row) begin
          r_orow <= r_orow + ROW_W'(1);
          r_ocol <= '0;
        end
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign win_clear      = (r_state == S_CLR);
  assign dbg_state      = r_state;
  assign bus.col_req    = (r_state == S_LOAD);
  assign bus.col_row    = r_orow;
  assign bus.col_col    = r_ncol;
  assign bus.pe_trigger = (r_state == S_TRIG);
  assign bus.out_valid  = (r_state == S_EMIT);
  assign bus.out_data   = r_out_data;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
endmodule

// File: tb/tb_conv_win_sched.sv
module tb_conv_win_sched;
  localparam int K_H     = 3;
  localparam int K_W     = 3;
  localparam int IN_H    = 4;
  localparam int IN_W    = 5;
  localparam int RES_W   = 24;
  localparam int OUT_W   = IN_W - K_W + 1;
  localparam int N_FETCH = (IN_H - K_H + 1) * IN_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0;
  logic col_gnt = 1'b0, res_valid = 1'b0, out_ready = 1'b0;
  logic signed [RES_W-1:0] res_data = '0;
  logic busy0, done0, clr0, busy1, done1, clr1;
  logic [2:0] st0, st1;

  conv_win_sched_if #(.IN_H(IN_H), .IN_W(IN_W), .RES_W(RES_W)) if0 ();
  conv_win_sched_if #(.IN_H(IN_H), .IN_W(IN_W), .RES_W(RES_W)) if1 ();

  assign if0.col_gnt   = col_gnt;
  assign if0.res_valid = res_valid;
  assign if0.res_data  = res_data;
  assign if0.out_ready = out_ready;
  assign if1.col_gnt   = col_gnt;
  assign if1.res_valid = res_valid;
  assign if1.res_data  = res_data;
  assign if1.out_ready = out_ready;

  conv_win_sched #(.K_H(K_H), .K_W(K_W), .IN_H(IN_H), .IN_W(IN_W), .RES_W(RES_W), .RELU(0)) dut0 (
    .clk(clk), .rst_ni(rst_ni), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .win_clear(clr0), .dbg_state(st0), .bus(if0.master)
  );

  conv_win_sched #(.K_H(K_H), .K_W(K_W), .IN_H(IN_H), .IN_W(IN_W), .RES_W(RES_W), .RELU(1)) dut1 (
    .clk(clk), .rst_ni(rst_ni), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .win_clear(clr1), .dbg_state(st1), .bus(if1.master)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [RES_W-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PE result for the k-th window of a pass.
  function automatic longint pe_val(input int k);
    if (k == 0) return -7;
    if (k == 1) return 12;
    return 100 * k - 250;
  endfunction

  function automatic longint relu(input longint v);
    return (v < 0) ? 0 : v;
  endfunction

  typedef struct {
    int gnt_idx;     // fetch index to stall col_gnt on (-1 none)
    int gnt_len;     // stall cycles
    int rdy_len;     // out_ready low cycles on first result
    int abort_win;   // window index whose WAIT gets an abort (-1 none)
    bit busy_start;  // pulse start while busy
    bit load_resv;   // pulse a stray res_valid during LOAD
    int exp_outs;
    int exp_fetch;
    int exp_clr;
    int exp_trig;
    int exp_done;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one image pass ----------------
  task automatic run_pass(input vec_t v, input int id);
    int fi, ko, nclr, ntrig, ndone, cd, gstall, rstall, cyc;
    bit fin, busy_lost, aborted, resv_done;
    longint ev;
    fi = 0; ko = 0; nclr = 0; ntrig = 0; ndone = 0; cd = 0; cyc = 0;
    gstall = v.gnt_len; rstall = v.rdy_len;
    fin = 0; busy_lost = 0; aborted = 0; resv_done = 0;
    exp_q.delete();
    for (int k = 0; k < v.exp_outs; k++) exp_q.push_back(RES_W'(pe_val(k)));

    start = 1'b1; col_gnt = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d busy_after_start", id), busy0, 1);

    while (!fin && cyc < 400) begin
      col_gnt = 1'b1; res_valid = 1'b0; res_data = '0;
      out_ready = 1'b1; abort = 1'b0; start = 1'b0;
      if (aborted) begin
        check($sformatf("v%0d abort_busy", id), busy0, 0);
        check($sformatf("v%0d abort_state", id), st0, 0);
        check($sformatf("v%0d abort_no_done", id), done0, 0);
        check($sformatf("v%0d abort_no_valid", id), if0.out_valid, 0);
        fin = 1;
      end else begin
        if (busy0 !== 1'b1) busy_lost = 1;
        if (clr0) nclr++;
        if (done0) begin ndone++; fin = 1; end
        if (if0.pe_trigger) begin
          ntrig++;
          cd = 2;
        end else if (cd > 0) begin
          cd--;
          if (v.abort_win >= 0 && ntrig == v.abort_win + 1 && cd == 1) begin
            abort = 1'b1;
            aborted = 1;
          end else if (cd == 0) begin
            res_valid = 1'b1;
            res_data = RES_W'(pe_val(ko));
          end
        end
        if (if0.col_req) begin
          if (fi < N_FETCH) begin
            check($sformatf("v%0d fetch_row[%0d]", id, fi), if0.col_row, fi / IN_W);
            check($sformatf("v%0d fetch_col[%0d]", id, fi), if0.col_col, fi % IN_W);
          end else begin
            check($sformatf("v%0d fetch_extra", id), fi, N_FETCH - 1);
          end
          if (v.load_resv && !resv_done && cd == 0) begin
            res_valid = 1'b1;
            res_data = RES_W'(999);
            resv_done = 1;
          end
          if (fi == v.gnt_idx && gstall > 0) begin
            col_gnt = 1'b0;
            gstall--;
            check($sformatf("v%0d stall_no_trig", id), ntrig, 0);
          end else begin
            fi++;
          end
        end
        if (if0.out_valid) begin
          if (v.busy_start && ko == 0) start = 1'b1;
          ev = (exp_q.size() > 0) ? longint'($signed(exp_q[0])) : 0;
          if (ko == 0 && rstall > 0) begin
            out_ready = 1'b0;
            rstall--;
            check($sformatf("v%0d hold_data", id), longint'(if0.out_data), ev);
            check($sformatf("v%0d hold_relu", id), longint'(if1.out_data), relu(ev));
            check($sformatf("v%0d hold_no_req", id), if0.col_req, 0);
          end else begin
            check($sformatf("v%0d out_row[%0d]", id, ko), if0.out_row, ko / OUT_W);
            check($sformatf("v%0d out_col[%0d]", id, ko), if0.out_col, ko % OUT_W);
            check($sformatf("v%0d out_data[%0d]", id, ko), longint'(if0.out_data), ev);
            check($sformatf("v%0d relu_data[%0d]", id, ko), longint'(if1.out_data), relu(ev));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            ko++;
          end
        end
      end
      cyc++;
      step();
    end
    col_gnt = 1'b0; res_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; start = 1'b0;

    if (!fin) check($sformatf("v%0d timeout", id), cyc, -1);
    check($sformatf("v%0d n_outputs", id), ko, v.exp_outs);
    check($sformatf("v%0d n_fetches", id), fi, v.exp_fetch);
    check($sformatf("v%0d n_win_clear", id), nclr, v.exp_clr);
    check($sformatf("v%0d n_pe_trigger", id), ntrig, v.exp_trig);
    check($sformatf("v%0d n_done", id), ndone, v.exp_done);
    check($sformatf("v%0d busy_held", id), busy_lost, 0);
    check($sformatf("v%0d idle_after", id), busy0, 0);
    check($sformatf("v%0d done_cleared", id), done0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{-1, 0, 0, -1, 1'b0, 1'b0, 6, 10, 2, 6, 1};
    tbl[1] = '{ 1, 5, 0, -1, 1'b0, 1'b0, 6, 10, 2, 6, 1};
    tbl[2] = '{-1, 0, 4, -1, 1'b0, 1'b0, 6, 10, 2, 6, 1};
    tbl[3] = '{-1, 0, 0,  2, 1'b0, 1'b0, 2,  5, 1, 3, 0};
    tbl[4] = '{-1, 0, 0, -1, 1'b0, 1'b0, 6, 10, 2, 6, 1};
    tbl[5] = '{-1, 0, 0, -1, 1'b1, 1'b1, 6, 10, 2, 6, 1};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_clear", clr0, 0);
    check("rst_state", st0, 0);
    check("rst_col_req", if0.col_req, 0);
    check("rst_col_col", if0.col_col, 0);
    check("rst_trigger", if0.pe_trigger, 0);
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_out_data", longint'(if0.out_data), 0);
    rst_ni = 1'b1;
    step();

    // start together with abort in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy0, 0);
    check("start_abort_clear", clr0, 0);
    step();

    for (int i = 0; i < 6; i++) begin
      run_pass(tbl[i], i);
      step();
    end

    // Asynchronous reset mid-pass, with the FSM parked in LOAD.
    start = 1'b1; col_gnt = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    check("mid_pre_req", if0.col_req, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_req", if0.col_req, 0);
    check("mid_rst_state", st0, 0);
    check("mid_rst_done", done0, 0);
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst_idle", busy0, 0);
    run_pass(tbl[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_win_sched.md
Name: conv_win_sched

Overview:
- Autonomous window scheduler for the convolution datapath. Replaces host-driven polling of load, trigger and readout.
- Walks output positions in raster order. For each position it fetches image columns from the column store, fires the PE trigger, waits for the PE result, and hands the result downstream over a valid/ready handshake.
- Sits between the host control register and the image circular register / PE array.

Parameters:
- K_H, 3, kernel height (pixels per fetched column).
- K_W, 3, kernel width (columns per full window).
- IN_H, 16, image height.
- IN_W, 15, image width.
- RES_W, 24, PE result width (signed).
- RELU, 0, 1 = clamp negative results to 0 before output.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start  in  1  begin one image pass. Ignored while busy.
- abort  in  1  synchronous abort, returns to IDLE.
- busy  out  1  high from the cycle after an accepted start until IDLE is re-entered.
- done  out  1  one-cycle pulse at end of pass.
- win_clear  out  1  one-cycle pulse; clears the image circular register.
- col_req  out  1  column fetch request.
- col_row  out  $clog2(IN_H)  top row of requested column (= current output row).
- col_col  out  $clog2(IN_W)  image column index requested.
- col_gnt  in  1  fetch accepted this cycle (handshake = col_req & col_gnt).
- pe_trigger  out  1  one-cycle pulse; start window MAC.
- res_valid  in  1  PE result valid this cycle.
- res_data  in  RES_W  signed PE result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  RES_W  captured result.
- out_row  out  $clog2(IN_H)  output row of out_data.
- out_col  out  $clog2(IN_W)  output column of out_data.

Behaviour:
- Derived sizes: OUT_H = IN_H-K_H+1, OUT_W = IN_W-K_W+1.
- Reset: all outputs 0. State = IDLE. Counters orow, ocol, ncol, ldcnt = 0.
- States: IDLE, CLR, LOAD, TRIG, WAIT, EMIT, DONE.
- IDLE: when start=1, go to CLR next cycle with orow=0, ocol=0.
- CLR: win_clear=1 for exactly one cycle. Then ncol=0, need=K_W, ldcnt=0, go to LOAD.
- LOAD:
  - col_req=1, col_row=orow, col_col=ncol.
  - col_row/col_col stay stable until the handshake.
  - On handshake: ncol++, ldcnt++.
  - When ldcnt reaches need (on the handshake cycle), go to TRIG.
  - Holding col_gnt low stalls LOAD indefinitely.
- TRIG: pe_trigger=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On res_valid: capture out_data = (RELU && res_data<0) ? 0 : res_data.
  - Capture out_row=orow, out_col=ocol, then go to EMIT.
  - res_valid in any other state is ignored.
- EMIT:
  - out_valid=1. out_data/out_row/out_col stay stable until out_ready.
  - On handshake:
    - ocol<OUT_W-1: ocol++, need=1, ldcnt=0, go to LOAD (sliding window; next col_col = ocol+K_W-1 after the increment).
    - ocol==OUT_W-1 and orow<OUT_H-1: orow++, ocol=0, go to CLR.
    - Last position: go to DONE.
  - out_valid drops the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency from window-complete to pe_trigger: 1 cycle. Minimum cycles per sliding output: 1 (LOAD) + 1 (TRIG) + PE latency + 1 (EMIT).
- abort=1 in any non-IDLE state:
  - Next state IDLE; all pulses and valids deassert next cycle; done is NOT pulsed.
  - Takes priority over every same-cycle handshake; that handshake is discarded.
- start with abort in the same IDLE cycle: abort wins, stay IDLE.
- Async reset mid-pass: immediate return to reset values. No output pulse.
- busy equivalent to state != IDLE.
- Column and row counters never exceed IN_W-1 / OUT_H-1. No wrap occurs inside a pass.

Test Plan:
- IN_H=4, IN_W=5, K=3, col_gnt=1, res_valid 2 cycles after trigger, out_ready=1 -> 6 outputs (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); 10 fetches with col_col sequence 0,1,2,3,4 per row; 2 win_clear; 6 pe_trigger; 1 done.
- Same config, col_gnt low 5 cycles on 2nd fetch -> col_col held at 1, no pe_trigger until granted; output set unchanged.
- out_ready low 4 cycles on first result (res_data=-7, RELU=0) -> out_valid held, out_data=-7 stable; no col_req during stall.
- RELU=1, res_data=-7 then +12 -> out_data 0 then 12.
- Assert abort in WAIT of 3rd window -> IDLE next cycle, busy=0, no done; new start reproduces full 6-output sequence from (0,0).
- start pulsed while busy, and res_valid pulsed in LOAD -> both ignored; outputs identical to the first scenario.
